// File: rtl/oam_dma.sv
// Sprite OAM DMA engine: a CPU write to TRIGGER_ADDR halts the CPU and copies
// XFER_LEN bytes from page {page, 00} to DEST_ADDR as alternating read/write cycles.
module oam_dma #(
    parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
    parameter logic [15:0] DEST_ADDR    = 16'h2004,
    parameter int          XFER_LEN     = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    input  logic        cpu_rd,
    input  logic [7:0]  mem_rdata,
    output logic        rdy,
    output logic        bus_own,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_wdata,
    output logic        dma_we,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        DUMMY,
        ALIGN,
        READ,
        WRITE,
        DONE
    } state_t;

    state_t     state;
    logic [7:0] page;
    logic [8:0] idx;
    logic [8:0] idx_inc;
    logic       parity;

    assign idx_inc = idx + 9'd1;

    // Outputs are registered, so each branch loads the values belonging to the
    // state being entered; dma_wdata doubles as the byte latch between READ and WRITE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            page      <= 8'd0;
            idx       <= 9'd0;
            parity    <= 1'b0;
            rdy       <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            bus_own   <= 1'b0;
            dma_we    <= 1'b0;
            dma_addr  <= 16'd0;
            dma_wdata <= 8'd0;
        end else begin
            parity    <= ~parity;
            done      <= 1'b0;
            bus_own   <= 1'b0;
            dma_we    <= 1'b0;
            dma_addr  <= 16'd0;
            dma_wdata <= 8'd0;
            case (state)
                IDLE: begin
                    if (cpu_we && cpu_addr == TRIGGER_ADDR) begin
                        page  <= cpu_wdata;
                        idx   <= 9'd0;
                        state <= HALT;
                        rdy   <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                HALT: begin
                    // Only a CPU read cycle may be stalled; writes always complete.
                    if (cpu_rd) begin
                        state <= DUMMY;
                    end
                end
                DUMMY: begin
                    // Reads must land on parity 0, so odd parity here goes straight to READ.
                    if (parity) begin
                        state    <= READ;
                        bus_own  <= 1'b1;
                        dma_addr <= {page, idx[7:0]};
                    end else begin
                        state <= ALIGN;
                    end
                end
                ALIGN: begin
                    state    <= READ;
                    bus_own  <= 1'b1;
                    dma_addr <= {page, idx[7:0]};
                end
                READ: begin
                    state     <= WRITE;
                    bus_own   <= 1'b1;
                    dma_we    <= 1'b1;
                    dma_addr  <= DEST_ADDR;
                    dma_wdata <= mem_rdata;
                end
                WRITE: begin
                    idx <= idx_inc;
                    if (int'(idx_inc) < XFER_LEN) begin
                        state    <= READ;
                        bus_own  <= 1'b1;
                        dma_addr <= {page, idx_inc[7:0]};
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                        rdy   <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    rdy   <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: full transfers for both parity alignments, HALT hold,
// page FF wrap, ignored retriggers, DONE-cycle trigger and mid-transfer reset.
module tb_oam_dma;

    localparam logic [15:0] TRIG = 16'h4014;
    localparam logic [15:0] DEST = 16'h2004;

    logic        clk;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_we;
    logic        cpu_rd;
    logic [7:0]  mem_rdata;
    logic        rdy;
    logic        bus_own;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_we;
    logic        busy;
    logic        done;

    int  checkCount = 0;
    int  passCount  = 0;
    logic parityModel;

    oam_dma dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_rd    (cpu_rd),
        .mem_rdata (mem_rdata),
        .rdy       (rdy),
        .bus_own   (bus_own),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_we    (dma_we),
        .busy      (busy),
        .done      (done)
    );

    function automatic logic [7:0] memByte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    assign mem_rdata = memByte(dma_addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running parity reference: cleared by reset, toggles on every other edge.
    always @(posedge clk) begin
        parityModel <= reset ? 1'b0 : ~parityModel;
    end

    task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
    endtask

    task automatic applyStimulus(input logic [7:0] pg, input int hold, input bit wantOdd,
                                 input int injectAt, input int abortAt, input string tag);
        int stall, readCount, writeCount, badRead, badWrite, badIdle, badRdy, cycles, extra;
        bit dummyParity, aborted, finished;
        stall = 0; readCount = 0; writeCount = 0; badRead = 0; badWrite = 0;
        badIdle = 0; badRdy = 0; cycles = 0; extra = 0; aborted = 0; finished = 0;
        if ((parityModel ^ hold[0]) != wantOdd) @(negedge clk);
        cpu_addr = TRIG; cpu_wdata = pg; cpu_we = 1'b1; cpu_rd = 1'b0;
        @(negedge clk);
        cpu_we = 1'b0; cpu_addr = 16'h0000;
        checkOutput({tag, "/halt_rdy_own_busy"}, {rdy, bus_own, busy}, 3'b001);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput({tag, "/halt_hold"}, {rdy, bus_own, busy, dma_we}, 4'b0010);
        end
        cpu_rd = 1'b1;
        @(negedge clk);
        cpu_rd = 1'b0;
        dummyParity = parityModel;
        checkOutput({tag, "/dummy_parity"}, dummyParity, wantOdd);
        checkOutput({tag, "/dummy_rdy_own_busy"}, {rdy, bus_own, busy}, 3'b001);
        stall = 1;
        while (!finished && cycles < 2000) begin
            @(negedge clk);
            cycles++;
            cpu_we = 1'b0; cpu_addr = 16'h0000;
            if (done) begin
                finished = 1;
            end else begin
                stall++;
                if (rdy !== 1'b0 || busy !== 1'b1) badRdy++;
                if (bus_own && !dma_we) begin
                    if (dma_addr !== {pg, readCount[7:0]}) badRead++;
                    readCount++;
                end else if (bus_own && dma_we) begin
                    if (dma_addr !== DEST || dma_wdata !== memByte({pg, writeCount[7:0]})) badWrite++;
                    writeCount++;
                end else if (dma_addr !== 16'h0000 || dma_wdata !== 8'h00 || dma_we !== 1'b0) begin
                    badIdle++;
                end
                if (injectAt >= 0 && bus_own && !dma_we && readCount == injectAt + 1) begin
                    cpu_we = 1'b1; cpu_addr = TRIG; cpu_wdata = 8'h05;
                end
                if (injectAt >= 0 && bus_own && !dma_we && readCount == injectAt + 3) begin
                    cpu_we = 1'b1; cpu_addr = 16'h4015; cpu_wdata = 8'h07;
                end
                if (abortAt >= 0 && dma_we && writeCount == abortAt + 1) begin
                    reset = 1'b1;
                    @(negedge clk);
                    reset = 1'b0;
                    aborted = 1;
                    finished = 1;
                end
            end
        end
        checkOutput({tag, "/no_timeout"}, finished, 1'b1);
        checkOutput({tag, "/stall_rdy_busy"}, badRdy, 0);
        checkOutput({tag, "/read_addrs"}, badRead, 0);
        checkOutput({tag, "/write_addr_data"}, badWrite, 0);
        checkOutput({tag, "/idle_bus_zero"}, badIdle, 0);
        if (aborted) begin
            checkOutput({tag, "/abort_outputs"}, {rdy, busy, done, bus_own, dma_we}, 5'b10000);
            checkOutput({tag, "/abort_addr"}, {dma_addr, dma_wdata}, 24'h0);
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (dma_we || done || busy || !rdy) extra++;
            end
            checkOutput({tag, "/abort_quiet"}, extra, 0);
        end else begin
            checkOutput({tag, "/done_outputs"}, {done, rdy, busy, bus_own, dma_we}, 5'b11000);
            checkOutput({tag, "/stall_cycles"}, stall, wantOdd ? 513 : 514);
            checkOutput({tag, "/read_count"}, readCount, 256);
            checkOutput({tag, "/write_count"}, writeCount, 256);
            cpu_addr = TRIG; cpu_wdata = 8'h77; cpu_we = 1'b1;
            @(negedge clk);
            cpu_we = 1'b0; cpu_addr = 16'h0000;
            checkOutput({tag, "/done_trigger_ignored"}, {done, rdy, busy}, 3'b010);
        end
    endtask

    initial begin
        reset = 1'b1; cpu_addr = 16'h0000; cpu_wdata = 8'h00; cpu_we = 1'b0; cpu_rd = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_outputs", {rdy, busy, done, bus_own, dma_we}, 5'b10000);
        checkOutput("reset_bus", {dma_addr, dma_wdata}, 24'h0);
        reset = 1'b0;
        cpu_addr = 16'h4015; cpu_wdata = 8'h09; cpu_we = 1'b1;
        @(negedge clk);
        cpu_addr = 16'h0014;
        @(negedge clk);
        cpu_we = 1'b0; cpu_addr = 16'h0000;
        @(negedge clk);
        checkOutput("other_addr_ignored", {rdy, busy, bus_own}, 3'b100);

        applyStimulus(8'h02, 0, 1'b1, -1, -1, "odd");
        applyStimulus(8'h02, 0, 1'b0, -1, -1, "even");
        applyStimulus(8'hFF, 3, 1'b1, -1, -1, "hold3_pageFF");
        applyStimulus(8'h02, 0, 1'b0, 16, -1, "retrigger");
        applyStimulus(8'h02, 0, 1'b1, -1, 100, "abort");
        applyStimulus(8'h40, 1, 1'b0, -1, -1, "after_abort");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
